cpu_boot_ctrl: RTL

//  Upstream run controller for cpu. Streams a program into instruction memory

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/cpu_boot_ctrl_if.sv | 46 ++++
 rtl/boot_down_counter.sv | 28 ++
 rtl/cpu_boot_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu boot/run controller.
// Covers the FSM state encodings, bus widths and ext-port byte address steps.
package cpu_pkg;

   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned IWORD_W = 32;
   localparam int unsigned DWORD_W = 64;

   localparam int unsigned IMEM_BYTE_STEP  = 4;
   localparam int unsigned DMEM_BYTE_STEP  = 8;
   localparam int unsigned IMEM_ADDR_SHIFT = $clog2(IMEM_BYTE_STEP);
   localparam int unsigned DMEM_ADDR_SHIFT = $clog2(DMEM_BYTE_STEP);

   localparam int unsigned ST_W = 3;
   typedef logic [ST_W-1:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_LOAD     = 3'd1;
   localparam state_t ST_RUN      = 3'd2;
   localparam state_t ST_DUMP_RD  = 3'd3;
   localparam state_t ST_DUMP_WT  = 3'd4;
   localparam state_t ST_DUMP_OUT = 3'd5;
   localparam state_t ST_DONE     = 3'd6;

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Control, program-load, cpu ext-port and dump-stream signals of the boot controller.
// The master side is the controller; the slave side is the surrounding system.
interface cpu_boot_ctrl_if
   import cpu_pkg::*;
#(
   parameter int unsigned CNT_W = 32
);
   logic               start;
   logic [CNT_W-1:0]   run_cycles;
   logic               busy;
   logic               done;
   logic               load_err;

   logic               load_valid;
   logic               load_ready;
   logic [IWORD_W-1:0] load_data;
   logic               load_last;

   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_wen;
   logic               imem_ren;
   logic [IWORD_W-1:0] imem_wdata;
   logic               cpu_enable;
   logic [ADDR_W-1:0]  dmem_addr;
   logic               dmem_ren;
   logic               dmem_wen;
   logic [DWORD_W-1:0] dmem_rdata;

   logic               dump_valid;
   logic               dump_ready;
   logic [DWORD_W-1:0] dump_data;
   logic               dump_last;

   modport master (
      input  start, run_cycles, load_valid, load_data, load_last, dmem_rdata, dump_ready,
      output busy, done, load_err, load_ready, imem_addr, imem_wen, imem_ren, imem_wdata,
             cpu_enable, dmem_addr, dmem_ren, dmem_wen, dump_valid, dump_data, dump_last
   );

   modport slave (
      output start, run_cycles, load_valid, load_data, load_last, dmem_rdata, dump_ready,
      input  busy, done, load_err, load_ready, imem_addr, imem_wen, imem_ren, imem_wdata,
             cpu_enable, dmem_addr, dmem_ren, dmem_wen, dump_valid, dump_data, dump_last
   );

endinterface

// File: rtl/boot_down_counter.sv
// Loadable down-counter with a zero flag; times how long the cpu stays enabled.
module boot_down_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             is_zero_c
);

   logic [CNT_W-1:0] cnt_q;

   // Saturates at zero so a stray decrement can never wrap.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign is_zero_c = (cnt_q == '0);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot/run controller: streams a program into cpu imem, runs the cpu for a set
// number of cycles, then dumps the first DUMP_WORDS of dmem as a valid/ready stream.
module cpu_boot_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 128,
   parameter int unsigned DUMP_WORDS = 16,
   parameter int unsigned CNT_W      = 32
) (
   input  logic            clk,
   input  logic            arst,
   cpu_boot_ctrl_if.master bus
);

   localparam int unsigned IDX_W  = $clog2(IMEM_DEPTH) + 1;
   localparam int unsigned DIDX_W = $clog2(DUMP_WORDS) + 1;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DIDX_W-1:0]   didx_q, didx_d;
   logic                load_ready_q, load_ready_d;
   logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic                imem_wen_q, imem_wen_d;
   logic [IWORD_W-1:0]  imem_wdata_q, imem_wdata_d;
   logic                cpu_enable_q, cpu_enable_d;
   logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
   logic                dmem_ren_q, dmem_ren_d;
   logic                dump_valid_q, dump_valid_d;
   logic [DWORD_W-1:0]  dump_data_q, dump_data_d;
   logic                dump_last_q, dump_last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                load_err_q, load_err_d;

   logic                cnt_load, cnt_dec, cnt_zero;
   logic                load_hs, dump_hs;

   boot_down_counter #(.CNT_W(CNT_W)) u_run_cnt (
      .clk       (clk),
      .arst      (arst),
      .load      (cnt_load),
      .load_val  (bus.run_cycles),
      .dec       (cnt_dec),
      .is_zero_c (cnt_zero)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      didx_d       = didx_q;
      imem_addr_d  = imem_addr_q;
      imem_wen_d   = 1'b0;
      imem_wdata_d = imem_wdata_q;
      cpu_enable_d = 1'b0;
      dmem_addr_d  = dmem_addr_q;
      dump_data_d  = dump_data_q;
      load_err_d   = load_err_q;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      load_hs      = bus.load_valid && load_ready_q;
      dump_hs      = bus.dump_ready && dump_valid_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d    = ST_LOAD;
               idx_d      = '0;
               didx_d     = '0;
               load_err_d = 1'b0;
               cnt_load   = 1'b1;
            end
         end
         ST_LOAD: begin
            if (load_hs) begin
               imem_wen_d   = 1'b1;
               imem_addr_d  = ADDR_W'(idx_q) << IMEM_ADDR_SHIFT;
               imem_wdata_d = bus.load_data;
               idx_d        = idx_q + IDX_W'(1);
               // A zero run length skips RUN so the cpu is never enabled.
               if (bus.load_last) begin
                  state_d = cnt_zero ? ST_DUMP_RD : ST_RUN;
               end else if (idx_q == IDX_W'(IMEM_DEPTH - 1)) begin
                  load_err_d = 1'b1;
                  state_d    = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            // First RUN cycle carries the final imem write, so enable starts one cycle later.
            if (!cnt_zero) begin
               cnt_dec      = 1'b1;
               cpu_enable_d = 1'b1;
            end else begin
               state_d = ST_DUMP_RD;
            end
         end
         ST_DUMP_RD: begin
            state_d = ST_DUMP_WT;
         end
         ST_DUMP_WT: begin
            dump_data_d = bus.dmem_rdata;
            state_d     = ST_DUMP_OUT;
         end
         ST_DUMP_OUT: begin
            if (dump_hs) begin
               if (didx_q == DIDX_W'(DUMP_WORDS - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  didx_d  = didx_q + DIDX_W'(1);
                  state_d = ST_DUMP_RD;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // State-decoded outputs are registered from the next state so they align with it.
      if (state_d == ST_DUMP_RD) begin
         dmem_addr_d = ADDR_W'(didx_d) << DMEM_ADDR_SHIFT;
      end
      load_ready_d = (state_d == ST_LOAD);
      dmem_ren_d   = (state_d == ST_DUMP_RD);
      dump_valid_d = (state_d == ST_DUMP_OUT);
      dump_last_d  = (state_d == ST_DUMP_OUT) && (didx_d == DIDX_W'(DUMP_WORDS - 1));
      busy_d       = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_DUMP_RD) ||
                     (state_d == ST_DUMP_WT) || (state_d == ST_DUMP_OUT);
      done_d       = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         idx_q        <= '0;
         didx_q       <= '0;
         load_ready_q <= 1'b0;
         imem_addr_q  <= '0;
         imem_wen_q   <= 1'b0;
         imem_wdata_q <= '0;
         cpu_enable_q <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_ren_q   <= 1'b0;
         dump_valid_q <= 1'b0;
         dump_data_q  <= '0;
         dump_last_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         didx_q       <= didx_d;
         load_ready_q <= load_ready_d;
         imem_addr_q  <= imem_addr_d;
         imem_wen_q   <= imem_wen_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_enable_q <= cpu_enable_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_ren_q   <= dmem_ren_d;
         dump_valid_q <= dump_valid_d;
         dump_data_q  <= dump_data_d;
         dump_last_q  <= dump_last_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         load_err_q   <= load_err_d;
      end
   end

   assign bus.load_ready = load_ready_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wen   = imem_wen_q;
   assign bus.imem_ren   = 1'b0;
   assign bus.imem_wdata = imem_wdata_q;
   assign bus.cpu_enable = cpu_enable_q;
   assign bus.dmem_addr  = dmem_addr_q;
   assign bus.dmem_ren   = dmem_ren_q;
   assign bus.dmem_wen   = 1'b0;
   assign bus.dump_valid = dump_valid_q;
   assign bus.dump_data  = dump_data_q;
   assign bus.dump_last  = dump_last_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.load_err   = load_err_q;

endmodule
